// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited instruction prefetcher with in-order response FIFO and redirect flush
module instr_fetch_unit #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] PC0 = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc, resp_pc, target;
  logic [AW:0] count, outstanding, discard_count, discard_nx, out_after;
  logic [AW+1:0] inflight;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] mem_data [DEPTH];
  logic [31:0] mem_pc [DEPTH];
  logic grant, rv_ok, push, pop;
  assign target = redirect_pc & 32'hFFFF_FFFC;
  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign grant = imem_req && imem_gnt;
  assign rv_ok = imem_rvalid && outstanding != '0;
  assign push = rv_ok && state == FETCH && !redirect;
  assign pop = instr_valid && instr_ready && !redirect;
  assign out_after = outstanding - (AW+1)'(rv_ok);
  assign imem_addr = fetch_pc;
  assign instr_valid = count != '0 && state != DRAIN;
  assign instr = instr_valid ? mem_data[rd_ptr] : NOP;
  assign instr_pc = instr_valid ? mem_pc[rd_ptr] : 32'h0;
  // request credit, drain bookkeeping and next state
  always_comb begin
    imem_req = state == FETCH && inflight < (AW+2)'(DEPTH) && !redirect;
    discard_nx = state == DRAIN ? discard_count - (AW+1)'(rv_ok) : (state == FETCH && redirect) ? out_after : '0;
    state_nx = state == IDLE ? FETCH
             : state == DRAIN ? (discard_nx == '0 ? FETCH : DRAIN)
             : (redirect && out_after != '0) ? DRAIN : FETCH;
  end
  // control state, fetch/response pcs and FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= PC0;
      resp_pc <= PC0;
      count <= '0;
      outstanding <= '0;
      discard_count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_nx;
      discard_count <= discard_nx;
      outstanding <= out_after + (AW+1)'(grant);
      fetch_pc <= redirect ? target : grant ? fetch_pc + 32'd4 : fetch_pc;
      resp_pc <= redirect ? target : push ? resp_pc + 32'd4 : resp_pc;
      count <= redirect ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
      rd_ptr <= redirect ? '0 : rd_ptr + AW'(pop);
      wr_ptr <= redirect ? '0 : wr_ptr + AW'(push);
    end
  end
  // FIFO storage: instruction word tagged with the pc it was fetched from
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= imem_rdata;
      mem_pc[wr_ptr] <= resp_pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: table-driven phases plus scoreboarded corner sequences for instr_fetch_unit
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { int rst_first; int n; int gmode; int rmode; int exp_grants; int exp_req; logic [31:0] exp_addr; } row_t;
  logic clk = 1'b0;
  logic rst;
  logic imem_req, imem_gnt, imem_rvalid, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  logic req2, valid2;
  logic [31:0] addr2, instr2, pc2;
  int n_cmp = 0;
  int n_bad = 0;
  int grants, discard;
  bit live, rv_en, junk_rv;
  logic [31:0] exp_addr;
  logic [31:0] mem_q[$];
  ent_t exp_q[$];
  logic s_req, s_valid, s_req2;
  logic [31:0] s_addr, s_pc, s_addr2;
  row_t rows [5];
  logic [31:0] wrap_exp [3];

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2), .imem_gnt(imem_gnt),
    .imem_rvalid(1'b0), .imem_rdata(32'h0), .redirect(1'b0), .redirect_pc(32'h0),
    .instr_valid(valid2), .instr(instr2), .instr_pc(pc2), .instr_ready(1'b0)
  );

  function automatic logic [31:0] data_of(input logic [31:0] pc);
    return ~pc ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_gnt = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    junk_rv = 1'b0;
    rv_en = 1'b1;
    mem_q.delete();
    exp_q.delete();
    discard = 0;
    live = 1'b0;
    exp_addr = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // one clock cycle: drive at negedge, check, advance the reference model across the edge
  task automatic cyc(input bit g, input bit r, input bit rd, input logic [31:0] rpc);
    logic [31:0] a;
    ent_t e;
    bit exp_req;
    imem_gnt = g;
    instr_ready = r;
    redirect = rd;
    redirect_pc = rpc;
    imem_rvalid = (rv_en && mem_q.size() > 0) || junk_rv;
    imem_rdata = 32'hDEAD_BEEF;
    if (rv_en && mem_q.size() > 0) imem_rdata = data_of(mem_q[0]);
    #1;
    s_req = imem_req;
    s_addr = imem_addr;
    s_valid = instr_valid;
    s_pc = instr_pc;
    s_req2 = req2;
    s_addr2 = addr2;
    exp_req = live && discard == 0 && (exp_q.size() + mem_q.size() < DEPTH) && !rd;
    check("imem_req", 64'(imem_req), 64'(exp_req));
    check("imem_addr", 64'(imem_addr), 64'(exp_addr));
    check("instr_valid", 64'(instr_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("instr_pc", 64'(instr_pc), 64'(exp_q[0].pc));
      check("instr", 64'(instr), 64'(exp_q[0].data));
    end else
      check("idle_outputs", {instr_pc, instr}, {32'h0, NOP});
    if (exp_q.size() != 0 && r && !rd) void'(exp_q.pop_front());
    if (imem_rvalid && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      if (!rd && discard == 0) begin
        e.pc = a;
        e.data = data_of(a);
        exp_q.push_back(e);
      end else if (!rd) discard--;
    end
    if (imem_req && g) begin
      mem_q.push_back(exp_addr);
      exp_addr = exp_addr + 32'd4;
      grants++;
    end
    if (rd) begin
      exp_q.delete();
      discard = mem_q.size();
      exp_addr = rpc & 32'hFFFF_FFFC;
    end
    live = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] pc);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      if (s_valid) begin
        seen = 1'b1;
        check(name, 64'(s_pc), 64'(pc));
      end
    end
    if (!seen) check({name, "_timeout"}, 64'(s_valid), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rows[0] = '{1, 12, 1, 1, 11, 1, 32'h28};
    rows[1] = '{1, 10, 1, 0, 4, 0, 32'h10};
    rows[2] = '{0, 8, 1, 1, 7, 1, 32'h28};
    rows[3] = '{0, 6, 0, 1, 0, 1, 32'h2C};
    rows[4] = '{0, 60, 2, 2, -1, -1, 32'h0};
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    imem_gnt = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_req", 64'(imem_req), 64'(0));
    check("rst_addr", 64'(imem_addr), 64'(0));
    check("rst_valid", 64'(instr_valid), 64'(0));
    check("rst_instr", {instr_pc, instr}, {32'h0, NOP});
    check("rst_addr2", 64'(addr2), 64'(32'hFFFF_FFF8));
    for (int i = 0; i < 5; i++) begin
      if (rows[i].rst_first != 0) do_reset();
      rv_en = 1'b1;
      grants = 0;
      for (int c = 0; c < rows[i].n; c++)
        cyc(rows[i].gmode == 2 ? 1'($urandom_range(0, 1)) : rows[i].gmode == 1,
            rows[i].rmode == 2 ? 1'($urandom_range(0, 1)) : rows[i].rmode == 1, 1'b0, 32'h0);
      if (rows[i].exp_grants >= 0) check($sformatf("row%0d_grants", i), 64'(grants), 64'(rows[i].exp_grants));
      if (rows[i].exp_req >= 0) begin
        check($sformatf("row%0d_req_end", i), 64'(s_req), 64'(rows[i].exp_req));
        check($sformatf("row%0d_addr_end", i), 64'(s_addr), 64'(rows[i].exp_addr));
      end
    end
    // redirect with two outstanding requests: drain both, refetch aligned target
    do_reset();
    rv_en = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0102);
    check("redir_req", 64'(s_req), 64'(0));
    rv_en = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("drain_req1", 64'(s_req), 64'(0));
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("drain_req2", 64'(s_req), 64'(0));
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("refetch_addr", 64'({s_req, s_addr}), 64'({1'b1, 32'h0000_0100}));
    wait_valid("refetch_pc", 32'h0000_0100);
    // second redirect while draining keeps the discard count
    do_reset();
    rv_en = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    cyc(1'b0, 1'b0, 1'b1, 32'h0000_0301);
    check("drain_redir_req", 64'(s_req), 64'(0));
    rv_en = 1'b1;
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("drain_redir_addr", 64'({s_req, s_addr}), 64'({1'b1, 32'h0000_0300}));
    wait_valid("drain_redir_pc", 32'h0000_0300);
    // redirect coincident with rvalid and instr_ready
    do_reset();
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    check("coinc_flushed", 64'(s_valid), 64'(0));
    check("coinc_refetch", 64'({s_req, s_addr}), 64'({1'b1, 32'h0000_0200}));
    wait_valid("coinc_pc", 32'h0000_0200);
    // address wrap from RESET_PC near the top of the address space
    do_reset();
    for (int c = 0; c < 4; c++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      if (c > 0) check($sformatf("wrap_addr%0d", c), 64'({s_req2, s_addr2}), 64'({1'b1, wrap_exp[c-1]}));
    end
    // asynchronous reset with three requests in flight; late responses ignored
    do_reset();
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    rv_en = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    check("pre_rst_valid", 64'(s_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", 64'(imem_req), 64'(0));
    check("async_rst_addr", 64'(imem_addr), 64'(0));
    check("async_rst_valid", 64'(instr_valid), 64'(0));
    check("async_rst_instr", {instr_pc, instr}, {32'h0, NOP});
    do_reset();
    junk_rv = 1'b1;
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 32'h0);
    junk_rv = 1'b0;
    wait_valid("post_rst_pc", 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
